// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
package rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  // Widest requester count the addr-slice helper can index.
  localparam int unsigned MAX_REQ = 8;

  function automatic logic [REG_AW-1:0] addr_slice(
    input logic [REG_AW*MAX_REQ-1:0] flat,
    input int unsigned               idx
  );
    return flat[idx*REG_AW +: REG_AW];
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic             found;
  int unsigned      k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (int'(rr_ptr_q) + i) % NREQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (advance) begin
      if (int'(grant_idx) == NREQ - 1) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback units and tracks
// pending destination registers in a busy scoreboard.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*REG_AW-1:0] req_addr,
  input  logic [NREQ*XLEN-1:0]   req_data,
  input  logic                   claim_valid,
  input  logic [REG_AW-1:0]      claim_addr,
  output logic                   claim_ok,
  input  logic [REG_AW-1:0]      rs1,
  input  logic [REG_AW-1:0]      rs2,
  output logic                   rs_hazard,
  output logic                   we_rf,
  output logic [REG_AW-1:0]      a3,
  output logic [XLEN-1:0]        wd,
  output logic                   sb_err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      transfer;
  logic [REG_AW*MAX_REQ-1:0] addr_pad;
  logic [REG_AW-1:0]         sel_addr;
  logic [XLEN-1:0]           sel_data;

  logic                      we_q;
  logic [REG_AW-1:0]         a3_q;
  logic [XLEN-1:0]           wd_q;
  logic                      sb_err_q;
  logic [NUM_REGS-1:0]       busy_q, busy_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .advance  (transfer),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign req_ready = reset ? '0 : grant;
  assign transfer  = |(req_valid & req_ready);

  always_comb begin
    addr_pad                  = '0;
    addr_pad[NREQ*REG_AW-1:0] = req_addr;
  end

  assign sel_addr = addr_slice(addr_pad, int'(grant_idx));
  assign sel_data = req_data[int'(grant_idx)*XLEN +: XLEN];

  // x0 never appears busy, so a claim of x0 always succeeds.
  assign claim_ok  = claim_valid & ~busy_q[claim_addr];
  assign rs_hazard = ((rs1 != REG_X0) & busy_q[rs1]) | ((rs2 != REG_X0) & busy_q[rs2]);

  // Commit clear and claim set; same-register overlap is excluded by claim_ok.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[a3_q] = 1'b0;
    end
    if (claim_ok && (claim_addr != REG_X0)) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      a3_q     <= '0;
      wd_q     <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (transfer) begin
        we_q <= (sel_addr != REG_X0);
        a3_q <= sel_addr;
        wd_q <= sel_data;
        if ((sel_addr != REG_X0) && !busy_q[sel_addr]) begin
          sb_err_q <= 1'b1;
        end
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign we_rf  = we_q;
  assign a3     = a3_q;
  assign wd     = wd_q;
  assign sb_err = sb_err_q;

endmodule
